// File: rtl/alu_share_arb.sv
// Time-shares one combinational 32-bit ALU between two valid/ready requesters (IDLE/EXEC/RESP).
// Define ALU_SHARE_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_share_arb #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid0,
   input  logic         req_valid1,
   output logic         req_ready0,
   output logic         req_ready1,
   input  logic [3:0]   req_op0,
   input  logic [3:0]   req_op1,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_b1,
   output logic         rsp_valid0,
   output logic         rsp_valid1,
   input  logic         rsp_ready0,
   input  logic         rsp_ready1,
   output logic [W-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state_q, state_d;
   logic [3:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [W-1:0]   result_q, result_d;
   logic [3:0]     flags_q, flags_d;
   logic           gnt_q, gnt_d;
   logic           arb_gnt;
`ifdef ALU_SHARE_RR_EN
   logic           last_grant_q, last_grant_d;
`endif

   logic [W:0]     sum, diff;
   logic [W-1:0]   alu_res;
   logic           alu_c, alu_v, alu_err, alu_z;

   // ALU: driven only by the captured operand registers
   always_comb begin
      sum     = {1'b0, a_q} + {1'b0, b_q};
      diff    = {1'b0, a_q} - {1'b0, b_q};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op_q)
         4'b0000: begin
            alu_res = sum[W-1:0];
            alu_c   = sum[W];
            alu_v   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
         end
         4'b1000: begin
            // carry on subtract reports a borrow (A < B unsigned)
            alu_res = diff[W-1:0];
            alu_c   = diff[W];
            alu_v   = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
         end
         4'b0001: alu_res = a_q & b_q;
         4'b0010: alu_res = a_q | b_q;
         4'b0011: alu_res = ~(a_q | b_q);
         4'b0110: alu_res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'b0111: alu_res = {{(W-1){1'b0}}, (a_q < b_q)};
         4'b1001: alu_res = b_q << 16;
         default: alu_err = 1'b1;
      endcase
      alu_z = (alu_res == '0);
   end

`ifdef ALU_SHARE_RR_EN
   always_comb begin
      if (req_valid0 && req_valid1) arb_gnt = ~last_grant_q;
      else                          arb_gnt = ~req_valid0;
   end
`else
   assign arb_gnt = ~req_valid0;
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      gnt_d      = gnt_q;
      result_d   = result_q;
      flags_d    = flags_q;
`ifdef ALU_SHARE_RR_EN
      last_grant_d = last_grant_q;
`endif
      req_ready0 = 1'b0;
      req_ready1 = 1'b0;
      rsp_valid0 = 1'b0;
      rsp_valid1 = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid0 || req_valid1) begin
               req_ready0 = ~arb_gnt;
               req_ready1 = arb_gnt;
               op_d       = arb_gnt ? req_op1 : req_op0;
               a_d        = arb_gnt ? req_a1  : req_a0;
               b_d        = arb_gnt ? req_b1  : req_b0;
               gnt_d      = arb_gnt;
`ifdef ALU_SHARE_RR_EN
               last_grant_d = arb_gnt;
`endif
               state_d    = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_res;
            flags_d  = {alu_err, alu_c, alu_v, alu_z};
            state_d  = RESP;
         end
         RESP: begin
            rsp_valid0 = ~gnt_q;
            rsp_valid1 = gnt_q;
            if (gnt_q ? rsp_ready1 : rsp_ready0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         gnt_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
`ifdef ALU_SHARE_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         gnt_q    <= gnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef ALU_SHARE_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;
   assign busy       = (state_q != IDLE);

endmodule
